// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// State codes double as the debug value exported on the state port.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_RWB      = 4'd3,
        S_EXEC_I   = 4'd4,
        S_IWB      = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000_000;
    localparam logic [5:0] OP_LW    = 6'b100_011;
    localparam logic [5:0] OP_SW    = 6'b101_011;
    localparam logic [5:0] OP_ADDI  = 6'b001_000;
    localparam logic [5:0] OP_ANDI  = 6'b001_100;
    localparam logic [5:0] OP_BEQ   = 6'b000_100;
    localparam logic [5:0] OP_J     = 6'b000_010;
    localparam logic [5:0] OP_JAL   = 6'b000_011;
    localparam logic [5:0] FUNCT_JR = 6'b001_000;

    localparam logic [5:0] ALU_ADD_CODE = 6'b000_000;
    localparam logic [5:0] ALU_SUB_CODE = 6'b000_100;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

    // States that hold a memory request open and are guarded by the wait timer.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been outstanding and flags the last allowed one.
// Count returns to zero whenever the request completes, times out or no request is open.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15   // legal range 1..255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] r_count;
    logic       w_timeout;

    assign w_timeout = i_active && !i_ready && (r_count == LIMIT);
    assign o_timeout = w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (!i_active || i_ready || w_timeout) begin
            r_count <= 8'd0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory wait
// handshake, timeout to trap and illegal-opcode trap.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int TRAP_VECTOR = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_wr_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         pc_source,
    output logic [3:0]         state,
    output logic               bus_err,
    output logic               illegal
);

    state_t r_state;
    state_t w_next;
    logic   r_trap_bus;     // TRAP entered from a memory timeout rather than a bad opcode
    logic   w_timeout;

    logic [ALUOP_W-1:0] w_op_ext;
    logic [ALUOP_W-1:0] w_sub;
    logic [ALUOP_W-1:0] w_add;

    assign w_op_ext = ALUOP_W'(opcode);
    assign w_sub    = ALUOP_W'(ALU_SUB_CODE);
    assign w_add    = ALUOP_W'(ALU_ADD_CODE);
    assign state    = r_state;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_active (is_mem_wait(r_state)),
        .i_ready  (mem_ready),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_trap_bus <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_trap_bus <= w_timeout;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:            w_next = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
                    OP_LW, OP_SW:    w_next = S_MEM_ADDR;
                    OP_ADDI, OP_ANDI: w_next = S_EXEC_I;
                    OP_BEQ:          w_next = S_BRANCH;
                    OP_J:            w_next = S_JUMP;
                    OP_JAL:          w_next = S_JAL;
                    default:         w_next = S_TRAP;
                endcase
            end
            S_EXEC_R:   w_next = S_RWB;
            S_EXEC_I:   w_next = S_IWB;
            S_MEM_ADDR: w_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)      w_next = S_MEM_WB;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready)      w_next = S_FETCH;
                else if (w_timeout) w_next = S_TRAP;
            end
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_wr_cond = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = M2R_ALUOUT;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_RT;
        alu_op     = w_add;
        pc_source  = PCSRC_ALU;
        bus_err    = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                // PC+4 and IR latch only on the completing cycle, so wait states
                // do not advance the PC repeatedly.
                if (mem_ready && !reset) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: alu_src_b = ALUB_IMM_SH;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_RT;
            end
            S_RWB: begin
                reg_dst    = REG_DST_RD;
                mem_to_reg = M2R_ALUOUT;
                reg_write  = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = w_op_ext;
            end
            S_IWB: begin
                reg_dst   = REG_DST_RT;
                reg_write = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_dst    = REG_DST_RT;
                mem_to_reg = M2R_MDR;
                reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = ALUB_RT;
                alu_op     = w_sub;
                pc_wr_cond = 1'b1;
                pc_source  = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                // Link value is the PC already advanced during FETCH.
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                reg_dst    = REG_DST_RA;
                mem_to_reg = M2R_PC;
                reg_write  = 1'b1;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_RS;
            end
            S_TRAP: begin
                bus_err = r_trap_bus;
                illegal = !r_trap_bus;
                if (TRAP_VECTOR != 0) begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_RS;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench: expands each instruction plus its memory-wait plan into an expected per-cycle trace
// and compares two DUTs (trap vector on / off) against it cycle by cycle.
module tb_multicycle_control_fsm;
    import mips_ctrl_pkg::*;

    localparam int MT = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mr, mw, irw;
        logic [1:0] rd, m2r;
        logic       rw, asa;
        logic [1:0] asb;
        logic [5:0] aop;
        logic [1:0] psrc;
        logic       be, ill;
    } obs_t;

    typedef struct packed {
        logic rdy;
        logic trap;
        obs_t o;
    } step_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       mem_ready;

    logic       pcw1, pcwc1, iord1, mr1, mw1, irw1, rw1, asa1, be1, ill1;
    logic [1:0] rd1, m2r1, asb1, psrc1;
    logic [5:0] aop1;
    logic [3:0] st1;
    logic       pcw0, pcwc0, iord0, mr0, mw0, irw0, rw0, asa0, be0, ill0;
    logic [1:0] rd0, m2r0, asb0, psrc0;
    logic [5:0] aop0;
    logic [3:0] st0;

    obs_t  g1, g0;
    step_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.ALUOP_W(6), .MEM_TIMEOUT(MT), .TRAP_VECTOR(1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pcw1), .pc_wr_cond(pcwc1), .iord(iord1), .mem_read(mr1), .mem_write(mw1),
        .ir_write(irw1), .reg_dst(rd1), .mem_to_reg(m2r1), .reg_write(rw1), .alu_src_a(asa1),
        .alu_src_b(asb1), .alu_op(aop1), .pc_source(psrc1), .state(st1), .bus_err(be1),
        .illegal(ill1));

    multicycle_control_fsm #(.ALUOP_W(6), .MEM_TIMEOUT(MT), .TRAP_VECTOR(0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pcw0), .pc_wr_cond(pcwc0), .iord(iord0), .mem_read(mr0), .mem_write(mw0),
        .ir_write(irw0), .reg_dst(rd0), .mem_to_reg(m2r0), .reg_write(rw0), .alu_src_a(asa0),
        .alu_src_b(asb0), .alu_op(aop0), .pc_source(psrc0), .state(st0), .bus_err(be0),
        .illegal(ill0));

    assign g1 = {st1, pcw1, pcwc1, iord1, mr1, mw1, irw1, rd1, m2r1, rw1, asa1, asb1, aop1, psrc1, be1, ill1};
    assign g0 = {st0, pcw0, pcwc0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, asa0, asb0, aop0, psrc0, be0, ill0};

    function automatic obs_t blank(input state_t s);
        obs_t o;
        o = '0;
        o.st = s;
        return o;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic trap, input obs_t o);
        step_t s;
        s.rdy = rdy; s.trap = trap; s.o = o;
        q.push_back(s);
    endtask

    // One memory access: 'waits' not-ready cycles then completion, or a timeout trap.
    task automatic add_access(input obs_t o, input int waits, input bit is_fetch, output bit ok);
        obs_t c, t;
        int n;
        n = (waits >= MT) ? MT : waits;
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, o);
        if (waits >= MT) begin
            ok = 1'b0;
            t = blank(S_TRAP);
            t.be = 1'b1; t.pcw = 1'b1; t.psrc = 2'b11;
            push(rnd_bit(), 1'b1, t);
        end else begin
            ok = 1'b1;
            c = o;
            if (is_fetch) begin
                c.pcw = 1'b1; c.irw = 1'b1;
            end
            push(1'b1, 1'b0, c);
        end
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wd);
        obs_t o;
        bit ok;
        q.delete();
        o = blank(S_FETCH); o.mr = 1'b1; o.asb = 2'b01;
        add_access(o, wf, 1'b1, ok);
        if (!ok) return;
        o = blank(S_DECODE); o.asb = 2'b11;
        push(rnd_bit(), 1'b0, o);
        if (op == 6'b000000 && fn == 6'b001000) begin
            o = blank(S_JR); o.pcw = 1'b1; o.psrc = 2'b11;
            push(rnd_bit(), 1'b0, o);
        end else if (op == 6'b000000) begin
            o = blank(S_EXEC_R); o.asa = 1'b1;
            push(rnd_bit(), 1'b0, o);
            o = blank(S_RWB); o.rd = 2'b01; o.rw = 1'b1;
            push(rnd_bit(), 1'b0, o);
        end else if (op == 6'b100011 || op == 6'b101011) begin
            o = blank(S_MEM_ADDR); o.asa = 1'b1; o.asb = 2'b10;
            push(rnd_bit(), 1'b0, o);
            if (op == 6'b100011) begin
                o = blank(S_MEM_RD); o.mr = 1'b1; o.iord = 1'b1;
                add_access(o, wd, 1'b0, ok);
                if (ok) begin
                    o = blank(S_MEM_WB); o.m2r = 2'b01; o.rw = 1'b1;
                    push(rnd_bit(), 1'b0, o);
                end
            end else begin
                o = blank(S_MEM_WR); o.mw = 1'b1; o.iord = 1'b1;
                add_access(o, wd, 1'b0, ok);
            end
        end else if (op == 6'b001000 || op == 6'b001100) begin
            o = blank(S_EXEC_I); o.asa = 1'b1; o.asb = 2'b10; o.aop = op;
            push(rnd_bit(), 1'b0, o);
            o = blank(S_IWB); o.rw = 1'b1;
            push(rnd_bit(), 1'b0, o);
        end else if (op == 6'b000100) begin
            o = blank(S_BRANCH); o.asa = 1'b1; o.aop = 6'd4; o.pcwc = 1'b1; o.psrc = 2'b01;
            push(rnd_bit(), 1'b0, o);
        end else if (op == 6'b000010) begin
            o = blank(S_JUMP); o.pcw = 1'b1; o.psrc = 2'b10;
            push(rnd_bit(), 1'b0, o);
        end else if (op == 6'b000011) begin
            o = blank(S_JAL); o.pcw = 1'b1; o.psrc = 2'b10; o.rd = 2'b10; o.m2r = 2'b10; o.rw = 1'b1;
            push(rnd_bit(), 1'b0, o);
        end else begin
            o = blank(S_TRAP); o.ill = 1'b1; o.pcw = 1'b1; o.psrc = 2'b11;
            push(rnd_bit(), 1'b1, o);
        end
    endtask

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Entered at a falling edge; leaves at a falling edge.
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn, input int limit);
        obs_t e0;
        int n;
        opcode = op;
        funct  = fn;
        n = (limit < 0 || limit > q.size()) ? q.size() : limit;
        for (int i = 0; i < n; i++) begin
            mem_ready = q[i].rdy;
            #1;
            e0 = q[i].o;
            if (q[i].trap) begin
                e0.pcw  = 1'b0;
                e0.psrc = 2'b00;
            end
            check({tag, "_tv1"}, g1, q[i].o);
            check({tag, "_tv0"}, g0, e0);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input int wf, input int wd);
        build(op, fn, wf, wd);
        run(tag, op, fn, -1);
    endtask

    initial begin
        obs_t f;
        logic [5:0] op, fn;
        int sel;
        reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        f = blank(S_FETCH); f.mr = 1'b1; f.asb = 2'b01;
        #1;
        check("reset_state", g1, f);
        check("reset_state_tv0", g0, f);
        reset = 1'b0;

        instr("r_type",    OP_R,        6'b100000, 0, 0);
        instr("lw_wait3",  OP_LW,       6'd0,      0, 3);
        instr("sw_timeout", OP_SW,      6'd0,      0, MT);
        instr("illegal",   6'b111111,   6'd0,      0, 0);
        instr("jal",       OP_JAL,      6'd0,      1, 0);
        instr("jr",        OP_R,        FUNCT_JR,  0, 0);
        instr("addi",      OP_ADDI,     6'd0,      2, 0);
        instr("andi",      OP_ANDI,     6'd0,      MT - 1, 0);
        instr("beq",       OP_BEQ,      6'd0,      0, 0);
        instr("j",         OP_J,        6'd0,      1, 0);
        instr("fetch_to",  OP_R,        6'd0,      MT, 0);
        instr("lw_to",     OP_LW,       6'd0,      0, MT);
        instr("sw_ok",     OP_SW,       6'd0,      2, MT - 1);

        // Reset during a MEM_WR wait: abort the write, restart at FETCH with a fresh count.
        build(OP_SW, 6'd0, 0, MT);
        run("sw_pre_reset", OP_SW, 6'd0, 5);
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        #1;
        f = blank(S_FETCH); f.mr = 1'b1; f.asb = 2'b01;
        check("reset_midwait", g1, f);
        check("reset_midwait_tv0", g0, f);
        instr("post_reset_to", OP_R, 6'd0, MT, 0);

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 10);
            fn  = 6'($urandom_range(0, 63));
            case (sel)
                0: op = OP_R;
                1: begin op = OP_R; fn = FUNCT_JR; end
                2: op = OP_LW;
                3: op = OP_SW;
                4: op = OP_ADDI;
                5: op = OP_ANDI;
                6: op = OP_BEQ;
                7: op = OP_J;
                8: op = OP_JAL;
                default: op = 6'($urandom_range(0, 63));
            endcase
            instr("rand", op, fn,
                  ($urandom_range(0, 5) == 0) ? MT : $urandom_range(0, MT - 1),
                  ($urandom_range(0, 5) == 0) ? MT : $urandom_range(0, MT - 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
